// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default sizing for the hazard controller.
// Channel FSM states and default parameter constants.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } chan_state_e;

    localparam int DEF_NSTG         = 9;
    localparam int DEF_DSTALL_DEPTH = 4;
    localparam int DEF_FLUSH_DEPTH  = 2;
    localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/miss_chan.sv
// One cache-miss channel: IDLE -> WAIT on miss, WAIT -> RELEASE on fill,
// RELEASE -> IDLE. Fill pulses arriving while IDLE are flagged sticky.
module miss_chan
    import hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic miss,
    input  logic fill,
    output logic stall,
    output logic busy,
    output logic fill_err
);

    chan_state_e state_q;
    chan_state_e state_d;
    logic        err_d;

    // State register and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            fill_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_err <= err_d;
        end
    end

    // Next state, stall and error detection.
    always_comb begin
        state_d = state_q;
        err_d   = fill_err;
        unique case (state_q)
            IDLE: begin
                if (fill) err_d = 1'b1;
                if (miss) state_d = WAIT;
            end
            WAIT: begin
                if (fill) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy | (state_q == IDLE && miss);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: I/D miss stalls, jump flushes, stall counters.
// Define HAZARD_CTRL_PERF_EN to build the stall-cycle counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NSTG         = DEF_NSTG,
    parameter int DSTALL_DEPTH = DEF_DSTALL_DEPTH,
    parameter int FLUSH_DEPTH  = DEF_FLUSH_DEPTH,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imiss,
    input  logic             ifill,
    input  logic             dmiss,
    input  logic             dfill,
    input  logic             jump,
    output logic             pc_we,
    output logic [NSTG-1:0]  stage_we,
    output logic [NSTG-1:0]  stage_reset,
    output logic             fill_err,
    output logic [CNT_W-1:0] istall_cnt,
    output logic [CNT_W-1:0] dstall_cnt
);

    logic istall;
    logic dstall;
    logic ibusy;
    logic d_busy_unused;
    logic i_err;
    logic d_err;
    logic flush_pend;

    miss_chan u_ichan (
        .clk      (clk),
        .reset    (reset),
        .miss     (imiss),
        .fill     (ifill),
        .stall    (istall),
        .busy     (ibusy),
        .fill_err (i_err)
    );

    miss_chan u_dchan (
        .clk      (clk),
        .reset    (reset),
        .miss     (dmiss),
        .fill     (dfill),
        .stall    (dstall),
        .busy     (d_busy_unused),
        .fill_err (d_err)
    );

    assign fill_err = i_err | d_err;

    // Remember a jump taken under an I-refill so the stale fetch gets dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= (jump & ibusy) | (flush_pend & istall);
        end
    end

    // Per-register enables and clears; reset forces every register to clear.
    always_comb begin
        pc_we       = ~(istall | dstall);
        stage_we    = '1;
        stage_reset = '0;
        if (dstall) begin
            for (int i = 0; i < NSTG; i++) begin
                if (i < DSTALL_DEPTH) stage_we[i] = 1'b0;
            end
        end else if (istall) begin
            stage_we[0] = 1'b0;
            for (int i = 0; i < NSTG; i++) begin
                if (i == 1) stage_reset[i] = 1'b1;
            end
        end
        if (jump) begin
            for (int i = 0; i < NSTG; i++) begin
                if (i < FLUSH_DEPTH) stage_reset[i] = 1'b1;
            end
        end
        if (flush_pend && !istall) stage_reset[0] = 1'b1;
        if (reset) begin
            pc_we       = 1'b0;
            stage_we    = '1;
            stage_reset = '1;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] icnt_q;
    logic [CNT_W-1:0] dcnt_q;

    // Saturating stall-cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (istall && icnt_q != '1) icnt_q <= icnt_q + CNT_W'(1);
            if (dstall && dcnt_q != '1) dcnt_q <= dcnt_q + CNT_W'(1);
        end
    end

    assign istall_cnt = icnt_q;
    assign dstall_cnt = dcnt_q;
`else
    assign istall_cnt = '0;
    assign dstall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector tables, corner sequences,
// and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int NSTG  = 9;
    localparam int DSD   = 4;
    localparam int FLD   = 2;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            imiss = 1'b0;
    logic            ifill = 1'b0;
    logic            dmiss = 1'b0;
    logic            dfill = 1'b0;
    logic            jump = 1'b0;
    logic            pc_we;
    logic [NSTG-1:0] stage_we;
    logic [NSTG-1:0] stage_reset;
    logic            fill_err;
    logic [CNT_W-1:0] istall_cnt;
    logic [CNT_W-1:0] dstall_cnt;

    hazard_ctrl #(
        .NSTG         (NSTG),
        .DSTALL_DEPTH (DSD),
        .FLUSH_DEPTH  (FLD),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imiss       (imiss),
        .ifill       (ifill),
        .dmiss       (dmiss),
        .dfill       (dfill),
        .jump        (jump),
        .pc_we       (pc_we),
        .stage_we    (stage_we),
        .stage_reset (stage_reset),
        .fill_err    (fill_err),
        .istall_cnt  (istall_cnt),
        .dstall_cnt  (dstall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: per channel, "outstanding" = miss accepted and fill not yet
    // seen; "tail" = the one extra stall cycle after the fill.
    bit     i_out, i_tail, d_out, d_tail;
    bit     i_err, d_err, pend;
    longint icnt, dcnt;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    typedef struct {
        bit             rst;
        logic           im, ifl, dm, dfl, jp;
        logic           pc;
        logic [NSTG-1:0] we, rs;
        int             tag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        i_out = 0; i_tail = 0; d_out = 0; d_tail = 0;
        i_err = 0; d_err = 0; pend = 0; icnt = 0; dcnt = 0;
    endtask

    task automatic chan_step(inout bit out, inout bit tail, inout bit err,
                             input logic miss, input logic fill);
        if (tail) begin
            tail = 0;
        end else if (out) begin
            if (fill) begin
                out = 0;
                tail = 1;
            end
        end else begin
            if (fill) err = 1;
            if (miss) out = 1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc_we"}, 64'(pc_we), 64'(0));
        chk({tag, "_stage_we"}, 64'(stage_we), 64'(9'h1FF));
        chk({tag, "_stage_reset"}, 64'(stage_reset), 64'(9'h1FF));
        chk({tag, "_fill_err"}, 64'(fill_err), 64'(0));
        chk({tag, "_istall_cnt"}, 64'(istall_cnt), 64'(0));
        chk({tag, "_dstall_cnt"}, 64'(dstall_cnt), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1; imiss = 0; ifill = 0; dmiss = 0; dfill = 0; jump = 0;
        #1;
        check_reset_state(tag);
        @(posedge clk);
        @(negedge clk);
        check_reset_state(tag);
        reset = 0;
        model_reset();
    endtask

    task automatic run_cycle(input logic im, ifl, dm, dfl, jp,
                             input bit hc, input logic hpc,
                             input logic [NSTG-1:0] hwe,
                             input logic [NSTG-1:0] hrs);
        bit istall, dstall, ibusy;
        logic ep;
        logic [NSTG-1:0] ewe, ers;
        @(posedge clk);
        #1;
        imiss = im; ifill = ifl; dmiss = dm; dfill = dfl; jump = jp;
        @(negedge clk);
        ibusy  = i_out | i_tail;
        istall = ibusy | im;
        dstall = d_out | d_tail | dm;
        ep  = !(istall || dstall);
        ewe = '1;
        ers = '0;
        if (dstall) ewe = ewe & ~NSTG'((1 << DSD) - 1);
        else if (istall) begin
            ewe[0] = 1'b0;
            ers[1] = 1'b1;
        end
        if (jp) ers = ers | NSTG'((1 << FLD) - 1);
        if (pend && !istall) ers[0] = 1'b1;
        chk("pc_we", 64'(pc_we), 64'(ep));
        chk("stage_we", 64'(stage_we), 64'(ewe));
        chk("stage_reset", 64'(stage_reset), 64'(ers));
        chk("fill_err", 64'(fill_err), 64'(i_err | d_err));
`ifdef HAZARD_CTRL_PERF_EN
        chk("istall_cnt", 64'(istall_cnt), 64'(icnt));
        chk("dstall_cnt", 64'(dstall_cnt), 64'(dcnt));
`else
        chk("istall_cnt_off", 64'(istall_cnt), 64'(0));
        chk("dstall_cnt_off", 64'(dstall_cnt), 64'(0));
`endif
        if (hc) begin
            chk("vec_pc_we", 64'(pc_we), 64'(hpc));
            chk("vec_stage_we", 64'(stage_we), 64'(hwe));
            chk("vec_stage_reset", 64'(stage_reset), 64'(hrs));
        end
        if (istall && icnt < CMAX) icnt++;
        if (dstall && dcnt < CMAX) dcnt++;
        pend = (jp && ibusy) || (pend && istall);
        chan_step(i_out, i_tail, i_err, im, ifl);
        chan_step(d_out, d_tail, d_err, dm, dfl);
    endtask

    task automatic add(input bit rst, input logic im, ifl, dm, dfl, jp,
                       input logic pc, input logic [NSTG-1:0] we, rs,
                       input int tag);
        vec_t v;
        v.rst = rst; v.im = im; v.ifl = ifl; v.dm = dm; v.dfl = dfl;
        v.jp = jp; v.pc = pc; v.we = we; v.rs = rs; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        model_reset();
        // I-miss, cycles 1-7
        add(1, 1,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 1,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 1,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 1,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 1,1,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 0,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 0,0,0,0,0, 1, 9'h1FF, 9'h000, 1);
        // D-miss, cycles 1-11
        add(1, 0,0,0,0,0, 1, 9'h1FF, 9'h000, 0);
        for (int c = 2; c <= 8; c++)
            add(0, 0,0,1,0,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 0,0,1,1,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 0,0,0,0,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 0,0,0,0,0, 1, 9'h1FF, 9'h000, 2);
        // jump during I WAIT
        add(1, 1,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 1,0,0,0,1, 0, 9'h1FE, 9'h003, 0);
        add(0, 1,1,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 0,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 0,0,0,0,0, 1, 9'h1FF, 9'h001, 0);
        add(0, 0,0,0,0,0, 1, 9'h1FF, 9'h000, 0);
        // overlapping I and D misses
        add(1, 1,0,1,0,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 1,0,1,0,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 1,0,1,1,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 1,0,0,0,0, 0, 9'h1F0, 9'h000, 0);
        add(0, 1,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 1,1,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 0,0,0,0,0, 0, 9'h1FE, 9'h002, 0);
        add(0, 0,0,0,0,0, 1, 9'h1FF, 9'h000, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst) do_reset("reset");
            run_cycle(vecs[k].im, vecs[k].ifl, vecs[k].dm, vecs[k].dfl,
                      vecs[k].jp, 1, vecs[k].pc, vecs[k].we, vecs[k].rs);
`ifdef HAZARD_CTRL_PERF_EN
            if (vecs[k].tag == 1)
                chk("istall_cnt_total", 64'(istall_cnt), 64'(6));
            if (vecs[k].tag == 2)
                chk("dstall_cnt_total", 64'(dstall_cnt), 64'(9));
`endif
        end

        // stray D fill: sticky error, no stall
        do_reset("reset");
        run_cycle(0,0,0,1,0, 1, 1, 9'h1FF, 9'h000);
        chk("fill_err_before", 64'(fill_err), 64'(0));
        for (int c = 0; c < 4; c++) begin
            run_cycle(0,0,0,0,0, 1, 1, 9'h1FF, 9'h000);
            chk("fill_err_sticky", 64'(fill_err), 64'(1));
        end
        do_reset("err_reset");
        run_cycle(0,0,0,0,0, 1, 1, 9'h1FF, 9'h000);
        chk("fill_err_cleared", 64'(fill_err), 64'(0));

        // reset mid D WAIT abandons the miss
        do_reset("reset");
        run_cycle(0,0,1,0,0, 1, 0, 9'h1F0, 9'h000);
        run_cycle(0,0,1,0,0, 1, 0, 9'h1F0, 9'h000);
        do_reset("mid_wait");
        run_cycle(0,0,0,0,0, 1, 1, 9'h1FF, 9'h000);
        chk("after_abort_icnt", 64'(istall_cnt), 64'(0));
        chk("after_abort_dcnt", 64'(dstall_cnt), 64'(0));
        run_cycle(0,0,0,1,0, 1, 1, 9'h1FF, 9'h000);

        // randomized traffic
        do_reset("reset");
        begin
            logic im, dm;
            im = 0;
            dm = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset("rand_reset");
                    im = 0;
                    dm = 0;
                end
                if ($urandom_range(0, 3) == 0) im = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) dm = 1'($urandom_range(0, 1));
                run_cycle(im,
                          1'($urandom_range(0, 3) == 0),
                          dm,
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 4) == 0),
                          0, 1'b0, '0, '0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTG, default 9: number of pipeline registers controlled, index 0 = IFID.
REQ-002 SHALL have parameter DSTALL_DEPTH, default 4: registers 0..DSTALL_DEPTH-1 frozen on a D-miss; legal range 1..NSTG.
REQ-003 SHALL have parameter FLUSH_DEPTH, default 2: registers 0..FLUSH_DEPTH-1 cleared on jump; legal range 1..NSTG.
REQ-004 SHALL have parameter CNT_W, default 32: stall counter width.
REQ-005 SHALL have clk  in  1  sole clock, rising edge.
REQ-006 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have imiss  in  1  I-cache miss, level.
REQ-008 SHALL have ifill  in  1  I-cache refill done, one-cycle pulse.
REQ-009 SHALL have dmiss  in  1  D-cache miss, level.
REQ-010 SHALL have dfill  in  1  D-cache refill done, one-cycle pulse.
REQ-011 SHALL have jump  in  1  taken branch/jump resolved this cycle.
REQ-012 SHALL have pc_we  out  1  PC write enable.
REQ-013 SHALL have stage_we  out  NSTG  per-register write enable.
REQ-014 SHALL have stage_reset  out  NSTG  per-register synchronous clear (bubble); overrides stage_we.
REQ-015 SHALL have fill_err  out  1  sticky: fill pulse seen with no miss outstanding.
REQ-016 SHALL have istall_cnt, dstall_cnt  out  CNT_W  stall-cycle counters.

Function
REQ-017 SHALL run one channel FSM per miss source (I, D), states IDLE, WAIT, RELEASE.
REQ-018 SHALL move IDLE->WAIT when miss=1; WAIT->RELEASE on fill=1; RELEASE->IDLE unconditionally next cycle.
REQ-019 SHALL ignore miss in WAIT/RELEASE; a miss still high in IDLE after RELEASE starts a new WAIT.
REQ-020 SHALL define chan stall = (state==IDLE & miss) | state==WAIT | state==RELEASE, so release happens one cycle after the fill pulse.
REQ-021 SHALL, on fill while channel is IDLE (including same cycle as miss), ignore the fill and set fill_err until reset.
REQ-022 SHALL, when dstall, drive pc_we=0 and stage_we[i]=0 for i<DSTALL_DEPTH.
REQ-023 SHALL, when istall and not dstall, drive pc_we=0, stage_we[0]=0, stage_reset[1]=1 (bubble into IDEX, never duplicate); with NSTG==1 the bubble is omitted.
REQ-024 SHALL keep every register not named above at stage_we=1, stage_reset=0.
REQ-025 SHALL, on jump, assert stage_reset[i] for i<FLUSH_DEPTH in the same cycle, regardless of stalls.
REQ-026 SHALL latch flush_pend when jump occurs while I-channel is WAIT or RELEASE, and assert stage_reset[0] in the first cycle istall is low, then clear flush_pend (discards the stale fetch).
REQ-027 SHALL allow simultaneous I and D misses; each channel advances independently; D rules dominate per REQ-022.
REQ-028 SHALL increment istall_cnt each cycle istall=1 and dstall_cnt each cycle dstall=1, saturating at all-ones.

Reset
REQ-029 SHALL, while reset=1: FSMs IDLE, flush_pend=0, fill_err=0, counters 0, pc_we=0, stage_we all 1, stage_reset all 1.
REQ-030 SHALL, on reset mid-miss, abandon the outstanding miss; the first cycle after deassertion follows REQ-020 from IDLE.

Configuration
REQ-031 SHALL, with HAZARD_CTRL_PERF_EN defined, implement REQ-028 counters.
REQ-032 SHALL, without HAZARD_CTRL_PERF_EN, keep istall_cnt/dstall_cnt ports tied to 0, no counter flops.

Structure
REQ-033 SHALL place state enum (IDLE/WAIT/RELEASE) and default parameter constants in package hazard_ctrl_pkg.
REQ-034 SHALL implement the channel FSM as sub-module miss_chan (in miss, fill; out stall, fill_err), instantiated twice.

Verification (NSTG=9, DSTALL_DEPTH=4, FLUSH_DEPTH=2, PERF on)
REQ-035 SHALL test imiss high cycles 1-5, ifill cycle 5 -> pc_we=0, stage_we[0]=0, stage_reset[1]=1 cycles 1-6; all release cycle 7; istall_cnt=6.
REQ-036 SHALL test dmiss cycles 2-9, dfill cycle 9 -> stage_we[3:0]=0, pc_we=0 cycles 2-10, stage_we[8:4]=1; dstall_cnt=9.
REQ-037 SHALL test jump during I WAIT -> stage_reset[1:0]=11 that cycle, stage_reset[0]=1 again in first cycle after release.
REQ-038 SHALL test dfill with no dmiss -> fill_err=1 next cycle, stays 1 until reset; no stall change.
REQ-039 SHALL test reset asserted mid D WAIT -> immediate stage_reset all 1, pc_we=0; after release no stall, counters 0.
REQ-040 SHALL test overlapping imiss and dmiss -> D freeze pattern, no stage_reset[1] bubble while dstall, I bubble resumes once D releases.
